// File: rtl/alu_pkg.sv
// Shared ALU types plus the command-sequencer state and frame header constants.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD      = 4'h0,
        SUB      = 4'h1,
        MUL      = 4'h2,
        DIV      = 4'h3,
        BIT_AND  = 4'h4,
        BIT_OR   = 4'h5,
        BIT_NAND = 4'h6,
        BIT_NOR  = 4'h7,
        BIT_XOR  = 4'h8,
        BIT_XNOR = 4'h9,
        CMP_EQ   = 4'hA,
        CMP_GT   = 4'hB,
        CMP_LT   = 4'hC,
        SHR      = 4'hD,
        SHL      = 4'hE,
        NOP      = 4'hF
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_A    = 3'd1,
        ST_GET_B    = 3'd2,
        ST_GET_FUN  = 3'd3,
        ST_EXEC     = 3'd4,
        ST_WAIT_RES = 3'd5,
        ST_SEND     = 3'd6
    } ctrl_state_e;

    localparam logic [7:0] HDR_FULL  = 8'hCC;
    localparam logic [7:0] HDR_REUSE = 8'hDD;

    // A FUN byte is legal only when its upper nibble is clear.
    function automatic logic fun_byte_ok(input logic [7:0] b);
        return b[7:4] == 4'h0;
    endfunction

endpackage

// File: rtl/alu_cmd_tx_ser.sv
// Result byte serializer: holds the result and sends it LSB first over valid/ready.
// ALU_CTRL_CHECKSUM_EN appends a checksum byte (lo ^ hi ^ fun).
module alu_cmd_tx_ser
    import alu_pkg::*;
#(
    parameter int OUT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [OUT_WIDTH-1:0] i_value,
    input  alu_op_e              i_fun,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic                 o_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
`ifdef ALU_CTRL_CHECKSUM_EN
    localparam logic [1:0] S_CHK  = 2'd3;
`endif

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [OUT_WIDTH-1:0] r_result;
    logic                 w_accept;
    logic [7:0]           w_chk;

`ifdef ALU_CTRL_CHECKSUM_EN
    assign w_chk = r_result[7:0] ^ r_result[15:8] ^ {4'h0, i_fun};
`else
    logic w_unused_fun;
    assign w_unused_fun = ^i_fun;
    assign w_chk        = 8'h00;
`endif

    assign o_tx_valid = (r_state != S_IDLE);
    assign w_accept   = o_tx_valid & i_tx_ready;

    always_comb begin
        w_state_next = r_state;
        o_done       = 1'b0;
        case (r_state)
            S_IDLE: if (i_start) w_state_next = S_LO;
            S_LO:   if (w_accept) w_state_next = S_HI;
            S_HI: begin
                if (w_accept) begin
`ifdef ALU_CTRL_CHECKSUM_EN
                    w_state_next = S_CHK;
`else
                    w_state_next = S_IDLE;
                    o_done       = 1'b1;
`endif
                end
            end
            default: begin
                if (w_accept) begin
                    w_state_next = S_IDLE;
                    o_done       = 1'b1;
                end
            end
        endcase
    end

    // Data is a pure function of held state, so it cannot move while stalled.
    always_comb begin
        o_tx_data = 8'h00;
        case (r_state)
            S_LO:    o_tx_data = r_result[7:0];
            S_HI:    o_tx_data = r_result[15:8];
            S_IDLE:  o_tx_data = 8'h00;
            default: o_tx_data = w_chk;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            if (i_start && (r_state == S_IDLE)) begin
                r_result <= i_value;
            end
        end
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Byte-stream command sequencer for the shared ALU; returns the result over TX.
// ALU_CTRL_CHECKSUM_EN (in alu_cmd_tx_ser) adds a third checksum response byte.
module alu_cmd_ctrl
    import alu_pkg::*;
#(
    parameter int                   OPER_WIDTH  = 8,
    parameter int                   OUT_WIDTH   = 16,
    parameter logic [OUT_WIDTH-1:0] DIV0_RESULT = 16'hFFFF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            RX_DATA,
    input  logic                  RX_VALID,
    output logic [OPER_WIDTH-1:0] ALU_A,
    output logic [OPER_WIDTH-1:0] ALU_B,
    output alu_op_e               ALU_FUN,
    output logic                  ALU_EN,
    input  logic [OUT_WIDTH-1:0]  ALU_OUT,
    input  logic                  ALU_OUT_VALID,
    output logic [7:0]            TX_DATA,
    output logic                  TX_VALID,
    input  logic                  TX_READY,
    output logic                  BUSY,
    output logic                  FRAME_ERR
);

    ctrl_state_e           r_state;
    ctrl_state_e           w_state_next;
    logic [OPER_WIDTH-1:0] r_a;
    logic [OPER_WIDTH-1:0] w_a_next;
    logic [OPER_WIDTH-1:0] r_b;
    logic [OPER_WIDTH-1:0] w_b_next;
    alu_op_e               r_fun;
    alu_op_e               w_fun_next;
    logic                  r_frame_err;
    logic                  w_frame_err;
    logic                  w_start;
    logic [OUT_WIDTH-1:0]  w_value;
    logic                  w_tx_done;
    alu_op_e               w_rx_fun;

    assign w_rx_fun = alu_op_e'(RX_DATA[3:0]);

    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_fun_next   = r_fun;
        w_frame_err  = 1'b0;
        w_start      = 1'b0;
        w_value      = ALU_OUT;
        case (r_state)
            ST_IDLE: begin
                if (RX_VALID) begin
                    if (RX_DATA == HDR_FULL) begin
                        w_state_next = ST_GET_A;
                    end else if (RX_DATA == HDR_REUSE) begin
                        w_state_next = ST_GET_FUN;
                    end else begin
                        w_frame_err = 1'b1;
                    end
                end
            end
            ST_GET_A: begin
                if (RX_VALID) begin
                    w_a_next     = RX_DATA[OPER_WIDTH-1:0];
                    w_state_next = ST_GET_B;
                end
            end
            ST_GET_B: begin
                if (RX_VALID) begin
                    w_b_next     = RX_DATA[OPER_WIDTH-1:0];
                    w_state_next = ST_GET_FUN;
                end
            end
            ST_GET_FUN: begin
                if (RX_VALID) begin
                    if (!fun_byte_ok(RX_DATA)) begin
                        w_frame_err  = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_fun_next = w_rx_fun;
                        // Divide by zero is answered locally; the ALU never fires.
                        if ((w_rx_fun == DIV) && (r_b == '0)) begin
                            w_start      = 1'b1;
                            w_value      = DIV0_RESULT;
                            w_state_next = ST_SEND;
                        end else begin
                            w_state_next = ST_EXEC;
                        end
                    end
                end
            end
            ST_EXEC: w_state_next = ST_WAIT_RES;
            ST_WAIT_RES: begin
                if (ALU_OUT_VALID) begin
                    w_start      = 1'b1;
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: if (w_tx_done) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_fun       <= ADD;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_a         <= w_a_next;
            r_b         <= w_b_next;
            r_fun       <= w_fun_next;
            r_frame_err <= w_frame_err;
        end
    end

    assign ALU_A     = r_a;
    assign ALU_B     = r_b;
    assign ALU_FUN   = r_fun;
    assign ALU_EN    = (r_state == ST_EXEC);
    assign BUSY      = (r_state != ST_IDLE);
    assign FRAME_ERR = r_frame_err;

    alu_cmd_tx_ser #(
        .OUT_WIDTH (OUT_WIDTH)
    ) u_tx_ser (
        .i_clk      (CLK),
        .i_rst_n    (RST),
        .i_start    (w_start),
        .i_value    (w_value),
        .i_fun      (r_fun),
        .o_tx_data  (TX_DATA),
        .o_tx_valid (TX_VALID),
        .i_tx_ready (TX_READY),
        .o_done     (w_tx_done)
    );

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Scoreboard bench for alu_cmd_ctrl: directed frames, then randomized frames with backpressure.
// Honours ALU_CTRL_CHECKSUM_EN for the expected response length.
module tb_alu_cmd_ctrl;
    import alu_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_DATA = 8'h00;
    logic        RX_VALID = 1'b0;
    logic [7:0]  ALU_A;
    logic [7:0]  ALU_B;
    alu_op_e     ALU_FUN;
    logic        ALU_EN;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VALID;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY = 1'b1;
    logic        BUSY;
    logic        FRAME_ERR;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned rdy_mode = 0;
    int unsigned en_cnt = 0;
    int unsigned err_cnt = 0;
    int unsigned busy_cnt = 0;
    int unsigned exp_en = 0;
    int unsigned exp_err = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  m_a = 8'h00;
    logic [7:0]  m_b = 8'h00;
    logic [3:0]  m_fun = 4'h0;
    logic [15:0] alu_res;
    logic        alu_vld;

    always #5 CLK = ~CLK;

    alu_cmd_ctrl dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_DATA       (RX_DATA),
        .RX_VALID      (RX_VALID),
        .ALU_A         (ALU_A),
        .ALU_B         (ALU_B),
        .ALU_FUN       (ALU_FUN),
        .ALU_EN        (ALU_EN),
        .ALU_OUT       (ALU_OUT),
        .ALU_OUT_VALID (ALU_OUT_VALID),
        .TX_DATA       (TX_DATA),
        .TX_VALID      (TX_VALID),
        .TX_READY      (TX_READY),
        .BUSY          (BUSY),
        .FRAME_ERR     (FRAME_ERR)
    );

    function automatic logic [15:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] f);
        logic [15:0] wa = {8'h00, a};
        logic [15:0] wb = {8'h00, b};
        case (f)
            4'h0:    return wa + wb;
            4'h1:    return wa - wb;
            4'h2:    return wa * wb;
            4'h3:    return (b == 8'h00) ? 16'hFFFF : wa / wb;
            4'h4:    return wa & wb;
            4'h5:    return wa | wb;
            4'h6:    return {8'h00, ~(a & b)};
            4'h7:    return {8'h00, ~(a | b)};
            4'h8:    return wa ^ wb;
            4'h9:    return {8'h00, ~(a ^ b)};
            4'hA:    return (a == b) ? 16'd1 : 16'd0;
            4'hB:    return (a > b) ? 16'd1 : 16'd0;
            4'hC:    return (a < b) ? 16'd1 : 16'd0;
            4'hD:    return wa >> 1;
            4'hE:    return wa << 1;
            default: return 16'h0000;
        endcase
    endfunction

    // Behavioural ALU with one-cycle registered latency.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            alu_vld <= 1'b0;
            alu_res <= 16'h0000;
        end else begin
            alu_vld <= ALU_EN;
            if (ALU_EN) alu_res <= alu_calc(ALU_A, ALU_B, 4'(ALU_FUN));
        end
    end
    assign ALU_OUT       = alu_res;
    assign ALU_OUT_VALID = alu_vld;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            case (rdy_mode)
                0:       TX_READY = 1'b1;
                1:       TX_READY = ($urandom_range(0, 2) != 0);
                default: TX_READY = 1'b0;
            endcase
        end
    end

    // Monitor: pops expected TX bytes on each handshake and checks hold under backpressure.
    initial begin
        logic       prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic [7:0] e;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                prev_stall = 1'b0;
            end else begin
                if (ALU_EN) en_cnt++;
                if (FRAME_ERR) err_cnt++;
                if (BUSY) busy_cnt++;
                if (prev_stall) begin
                    chk("tx_hold_valid", 32'(TX_VALID), 32'd1);
                    chk("tx_hold_data", 32'(TX_DATA), 32'(prev_data));
                end
                if (TX_VALID && TX_READY) begin
                    if (exp_q.size() == 0) begin
                        chk("tx_unexpected", 32'(TX_DATA), 32'h100);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_byte", 32'(TX_DATA), 32'(e));
                    end
                end
                prev_stall = TX_VALID && !TX_READY;
                prev_data  = TX_DATA;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic rx(input logic [7:0] b);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        @(posedge CLK);
        #1;
        RX_VALID = 1'b0;
    endtask

    // Model of a FUN byte arriving with the stored operands m_a/m_b.
    task automatic model_fun(input logic [7:0] f);
        logic [15:0] r;
        if (f[7:4] != 4'h0) begin
            exp_err++;
        end else begin
            m_fun = f[3:0];
            if (m_fun == 4'h3 && m_b == 8'h00) begin
                r = 16'hFFFF;
            end else begin
                r = alu_calc(m_a, m_b, m_fun);
                exp_en++;
            end
            exp_q.push_back(r[7:0]);
            exp_q.push_back(r[15:8]);
`ifdef ALU_CTRL_CHECKSUM_EN
            exp_q.push_back(r[7:0] ^ r[15:8] ^ {4'h0, m_fun});
`endif
        end
    endtask

    task automatic full_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
        m_a = a;
        m_b = b;
        model_fun(f);
        rx(HDR_FULL);
        rx(a);
        rx(b);
        rx(f);
    endtask

    task automatic reuse_frame(input logic [7:0] f);
        model_fun(f);
        rx(HDR_REUSE);
        rx(f);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((BUSY || exp_q.size() != 0) && n < 400) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (n >= 400) chk("idle_timeout", 32'(n), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        chk("alu_en_count", en_cnt, exp_en);
        chk("frame_err_count", err_cnt, exp_err);
        chk("alu_a", 32'(ALU_A), 32'(m_a));
        chk("alu_b", 32'(ALU_B), 32'(m_b));
        chk("alu_fun", 32'(ALU_FUN), 32'(m_fun));
    endtask

    initial begin
        int n;
        logic [7:0] a, b, f, h;
        int unsigned kind;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_alu_a", 32'(ALU_A), 32'd0);
        chk("rst_alu_b", 32'(ALU_B), 32'd0);
        chk("rst_alu_fun", 32'(ALU_FUN), 32'd0);
        chk("rst_alu_en", 32'(ALU_EN), 32'd0);
        chk("rst_tx_valid", 32'(TX_VALID), 32'd0);
        chk("rst_tx_data", 32'(TX_DATA), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_frame_err", 32'(FRAME_ERR), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // ADD with TX_READY high: first TX_VALID three cycles after the FUN strobe.
        full_frame(8'h12, 8'h34, 8'h00);
        n = 0;
        while (!TX_VALID && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("add_latency", 32'(n + 1), 32'd3);
        wait_idle();
        chk("add_busy_after", 32'(BUSY), 32'd0);

        // MUL with five stalled cycles in SEND_LO.
        rdy_mode = 2;
        full_frame(8'hFF, 8'hFF, 8'h02);
        n = 0;
        while (!TX_VALID && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        repeat (5) begin
            chk("mul_stall_data", 32'(TX_DATA), 32'h01);
            @(posedge CLK);
            #1;
        end
        rdy_mode = 0;
        wait_idle();

        reuse_frame(8'h01);
        wait_idle();

        full_frame(8'h07, 8'h00, 8'h03);
        wait_idle();

        busy_cnt = 0;
        exp_err++;
        rx(8'h55);
        wait_idle();
        chk("bad_hdr_busy_cycles", busy_cnt, 32'd0);

        full_frame(8'h01, 8'h02, 8'h1F);
        wait_idle();

        // Reset mid-frame after CC,AA.
        rx(HDR_FULL);
        rx(8'hAA);
        RST = 1'b0;
        m_a = 8'h00;
        m_b = 8'h00;
        m_fun = 4'h0;
        @(negedge CLK);
        chk("midrst_alu_a", 32'(ALU_A), 32'd0);
        chk("midrst_busy", 32'(BUSY), 32'd0);
        chk("midrst_tx_valid", 32'(TX_VALID), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        reuse_frame(8'h00);
        wait_idle();

        // Randomized frames under random backpressure with stray bytes while busy.
        rdy_mode = 1;
        repeat (60) begin
            kind = $urandom_range(0, 5);
            a = 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            f = {4'h0, 4'($urandom)};
            if (kind == 5) f = 8'h03;
            case (kind)
                0, 5: full_frame(a, b, f);
                1:    reuse_frame(f);
                2: begin
                    h = 8'($urandom);
                    if (h == HDR_FULL || h == HDR_REUSE) h = 8'h00;
                    exp_err++;
                    rx(h);
                end
                3:       full_frame(a, b, {4'($urandom_range(1, 15)), f[3:0]});
                default: reuse_frame({4'($urandom_range(1, 15)), f[3:0]});
            endcase
            if (kind == 0 || kind == 1 || kind == 5) rx(8'($urandom));
            wait_idle();
        end
        rdy_mode = 0;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
